adder_share_arbiter: RTL
========================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one ripple_carry_adder_4bit among NUM_REQ requesters using a round-robin arbiter.
//  Each requester presents operands a/b with a valid/ready handshake.
//  The granted pair is added and the sum/carry registered into a one-entry response slot.
//  The result leaves on a valid/ready response port tagged with the requester id.
//  The block sits between the adder datapath and the client blocks that need 4-bit adds.
// PARAMETERS
//  NUM_REQ  2  number of requesters (2..4)
//  ADD_W    4  operand width; fixed to the adder width, not user-changeable
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              reset, asynchronous assert, active-low
//  req_valid  in   NUM_REQ        per-requester operand valid
//  req_ready  out  NUM_REQ        per-requester accept (one-hot or zero)
//  req_a      in   NUM_REQ*ADD_W  packed operand a; requester i at [i*ADD_W +: ADD_W]
//  req_b      in   NUM_REQ*ADD_W  packed operand b; same packing
//  rsp_valid  out  1              response slot holds a result
//  rsp_ready  in   1              downstream accepts the response
//  rsp_sum    out  ADD_W          registered a+b, low ADD_W bits
//  rsp_cout   out  1              registered carry out of the add
//  rsp_id     out  ID_W           index of the requester that owns this result
// BEHAVIOUR
//  Reset values
//   - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rr_ptr=0, state=EMPTY.
//   - req_ready=0 while rst_n=0.
//  State machine (response slot)
//   - States are EMPTY and FULL.
//   - can_accept = (state==EMPTY) | (state==FULL & rsp_ready).
//  Arbitration
//   - Round-robin starting at rr_ptr.
//   - The winner is the first index i, scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ), with req_valid[i]=1.
//   - req_ready[winner] = can_accept. All other req_ready bits are 0.
//   - req_ready is combinational from req_valid, state and rsp_ready.
//  Accept cycle (some req_valid[i] & req_ready[i])
//   - Drive the adder with req_a/req_b of the winner.
//   - On the next edge: {rsp_cout, rsp_sum} <= adder output, rsp_id <= winner, state <= FULL.
//   - On the same edge: rr_ptr <= (winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
//  Latency and throughput
//   - Latency is 1 cycle: a handshake at edge T gives rsp_valid=1 after edge T.
//   - Throughput is 1 result/cycle while rsp_ready=1.
//  Drain
//   - FULL & rsp_ready & no accept -> EMPTY, rsp_valid <= 0.
//   - Simultaneous drain and accept -> stay FULL with the new result; no bubble.
//  Backpressure
//   - FULL & !rsp_ready: rsp_* is held stable, every req_ready bit is 0, rr_ptr is held.
//  Requester rules
//   - Once req_valid is asserted, the requester holds it and its operands until the handshake.
//   - rr_ptr advances only on an accept, never on idle cycles.
//  Arithmetic
//   - Unsigned add. Carry-in is 0.
//   - sum = (a+b) mod 16; cout = (a+b) > 15.
//  Reset mid-operation
//   - rst_n falling clears the response slot and rr_ptr immediately.
//   - A pending result is discarded and is not replayed.
//  No request pending -> all req_ready=0 and state is unchanged.
// STRUCTURE
//  Package adder_arb_pkg
//   - ADD_W=4 and MAX_REQ=4.
//   - ID_W=$clog2(MAX_REQ); rsp_id uses this width for every NUM_REQ.
//   - typedef enum logic {EMPTY, FULL} slot_state_t.
//  Sub-module
//   - One instance of ripple_carry_adder_4bit (a, b, sum, cout) for the datapath.
//   - The arbiter is in-line logic; it is not a separate module.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid=2'b11 -> rsp_valid=0, req_ready=2'b00; release -> first grant goes to req 0.
//  2 Single request: req0 a=0101 b=0011, rsp_ready=1 -> next cycle rsp_valid=1, sum=1000, cout=0, id=0.
//  3 Carry: req1 a=1111 b=0001 -> sum=0000, cout=1, id=1; a=1010 b=1101 -> sum=0111, cout=1.
//  4 Fairness: both valid continuously, rsp_ready=1 -> one grant per cycle, ids alternate 0,1,0,1.
//  5 Backpressure: rsp_ready=0 for 3 cycles while FULL -> rsp_* stable, req_ready=00; rsp_ready=1 -> drain and accept on the same edge.
//  6 Async reset while FULL: drop rst_n mid-cycle -> rsp_valid=0 before the next clock edge; rr_ptr returns to 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// +--------------------------------------------------------------------+
// | adder_arb_pkg: shared widths and slot state type for the adder arb |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package adder_arb_pkg;

  localparam int ADD_W   = 4;
  localparam int MAX_REQ = 4;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/ripple_carry_adder_4bit.sv
// +--------------------------------------------------------------------+
// | ripple_carry_adder_4bit: unsigned ADD_W-bit adder, carry-in tied 0 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ripple_carry_adder_4bit
  import adder_arb_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] sum,
  output logic             cout
);

  logic [ADD_W:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar i = 0; i < ADD_W; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[ADD_W];

endmodule

`default_nettype wire

// File: rtl/adder_share_arbiter.sv
// +--------------------------------------------------------------------+
// | adder_share_arbiter: round-robin share of one 4-bit adder, 1-deep  |
// | registered response slot.  Revision: 1.0                           |
// +--------------------------------------------------------------------+
`default_nettype none

module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADD_W-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id
);

  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  slot_state_t                 state;
  logic [ID_W-1:0]             rr_ptr;
  logic [ID_W-1:0]             winner;
  logic                        found;
  logic                        accept;
  logic [ID_W:0]               cand;
  logic [(2**(ID_W+1))-1:0]    valid_ext;
  logic [ADD_W-1:0]            add_a;
  logic [ADD_W-1:0]            add_b;
  logic [ADD_W-1:0]            add_sum;
  logic                        add_cout;

  // Scan from the far end back toward rr_ptr so the last hit is the
  // closest valid requester at or after the pointer.
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (valid_ext[cand]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  assign accept = rst_n & found & ((state == EMPTY) | rsp_ready);

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        req_ready[i] = accept;
        add_a        = req_a[i*ADD_W +: ADD_W];
        add_b        = req_b[i*ADD_W +: ADD_W];
      end
    end
  end

  ripple_carry_adder_4bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else if (accept) begin
      state    <= FULL;
      rsp_sum  <= add_sum;
      rsp_cout <= add_cout;
      rsp_id   <= winner;
      rr_ptr   <= (winner == LAST_ID) ? '0 : winner + 1'b1;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

`default_nettype wire
